// File: rtl/fetch_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller_if
// Description : Bundles the fetch-controller signals: hazard stall, branch
//               redirect, instruction-memory handshake, and the PC / IF-ID
//               control outputs. slave = controller side, master = the
//               surrounding pipeline (or a testbench).
//               Ports:
//                 stall, branchTaken, branchTarget, memReady   -> controller
//                 memReq, PCWrite, PCSrc, IFIDWrite, IFFlush,
//                 redirectPC, fetchCount                       <- controller
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_controller_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
);
  logic                   stall;
  logic                   branchTaken;
  logic [ADDR_WIDTH-1:0]  branchTarget;
  logic                   memReady;
  logic                   memReq;
  logic                   PCWrite;
  logic                   PCSrc;
  logic                   IFIDWrite;
  logic                   IFFlush;
  logic [ADDR_WIDTH-1:0]  redirectPC;
  logic [COUNT_WIDTH-1:0] fetchCount;

  modport slave (
    input  stall, branchTaken, branchTarget, memReady,
    output memReq, PCWrite, PCSrc, IFIDWrite, IFFlush, redirectPC, fetchCount
  );

  modport master (
    output stall, branchTaken, branchTarget, memReady,
    input  memReq, PCWrite, PCSrc, IFIDWrite, IFFlush, redirectPC, fetchCount
  );
endinterface
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : Instruction-fetch sequencing controller. Arbitrates between
//               the instruction-memory handshake, the hazard-unit stall and a
//               resolved taken branch; drives PC load/select, memory request
//               and IF/ID write/flush. Holds the redirect target and a
//               committed-fetch counter.
//               Ports:
//                 clock  - rising-edge system clock
//                 reset  - synchronous, active-high
//                 bus    - fetch_controller_if.slave (handshake + controls)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller #(
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  wire                 clock,
  input  wire                 reset,
  fetch_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_STALL = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [ADDR_WIDTH-1:0]  r_redirectPC;
  logic [COUNT_WIDTH-1:0] r_fetchCount;
  logic                   w_commit;

  // Control outputs are combinational from state and inputs; reset forces
  // them all low so a memory that also sits in reset sees no request.
  always_comb begin
    bus.memReq   = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSrc    = 1'b0;
    bus.IFIDWrite = 1'b0;
    bus.IFFlush  = 1'b0;
    w_commit     = 1'b0;
    w_nextState  = r_state;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          bus.memReq = 1'b1;
          if (bus.branchTaken) begin
            bus.IFFlush = 1'b1;
            if (bus.memReady) begin
              // Request completes this cycle: redirect immediately.
              bus.PCWrite = 1'b1;
              bus.PCSrc   = 1'b1;
            end else begin
              // Request still in flight: let it finish, then redirect.
              w_nextState = S_DRAIN;
            end
          end else if (bus.memReady) begin
            if (bus.stall) begin
              w_nextState = S_STALL;
            end else begin
              bus.PCWrite   = 1'b1;
              bus.IFIDWrite = 1'b1;
              w_commit      = 1'b1;
            end
          end
        end
        S_STALL: begin
          if (bus.branchTaken) begin
            bus.PCWrite = 1'b1;
            bus.PCSrc   = 1'b1;
            bus.IFFlush = 1'b1;
            w_nextState = S_FETCH;
          end else if (!bus.stall) begin
            // PC was never written, so re-entering FETCH refetches it.
            w_nextState = S_FETCH;
          end
        end
        S_DRAIN: begin
          bus.memReq  = 1'b1;
          bus.IFFlush = 1'b1;
          if (bus.memReady) begin
            bus.PCWrite = 1'b1;
            bus.PCSrc   = 1'b1;
            w_nextState = S_FETCH;
          end
        end
        default: w_nextState = S_FETCH;
      endcase
    end
  end

  // The IF mux takes branchTarget directly in the cycle branchTaken is seen;
  // the registered copy serves the deferred redirect out of DRAIN. Any new
  // branch overwrites it, so the newest target always wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_redirectPC <= '0;
      r_fetchCount <= '0;
    end else begin
      r_state <= w_nextState;
      if (bus.branchTaken) begin
        r_redirectPC <= bus.branchTarget;
      end
      if (w_commit) begin
        r_fetchCount <= r_fetchCount + 1'b1;
      end
    end
  end

  assign bus.redirectPC = r_redirectPC;
  assign bus.fetchCount = r_fetchCount;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_controller
// Description : Directed self-checking bench for fetch_controller. Each
//               vector sets the inputs, checks the combinational controls at
//               the falling edge as {memReq,PCWrite,PCSrc,IFIDWrite,IFFlush},
//               then checks registered state after the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nErrors = 0;

  always #5 clock = ~clock;

  fetch_controller_if #(.ADDR_WIDTH(16), .COUNT_WIDTH(16)) bus ();

  fetch_controller #(.ADDR_WIDTH(16), .COUNT_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [4:0] outs();
    return {bus.memReq, bus.PCWrite, bus.PCSrc, bus.IFIDWrite, bus.IFFlush};
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setIn(input logic st, input logic br, input logic [15:0] tgt,
                       input logic rdy);
    bus.stall        = st;
    bus.branchTaken  = br;
    bus.branchTarget = tgt;
    bus.memReady     = rdy;
  endtask

  // One clock: check controls mid-cycle, then step past the rising edge.
  task automatic runCycle(input string tag, input logic [4:0] exp);
    @(negedge clock);
    checkValue(tag, 32'(outs()), 32'(exp));
    @(posedge clock);
    #1;
  endtask

  task automatic checkRegs(input string tag, input logic [15:0] pc,
                           input logic [15:0] cnt);
    checkValue({tag, ".redirectPC"}, 32'(bus.redirectPC), 32'(pc));
    checkValue({tag, ".fetchCount"}, 32'(bus.fetchCount), 32'(cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    setIn(1'b0, 1'b0, 16'h0000, 1'b1);
    @(posedge clock);
    #1;
    // Reset: memReady ignored, every control low.
    runCycle("reset.outs", 5'b00000);
    checkRegs("reset", 16'h0000, 16'd0);
    reset = 1'b0;

    // Single-cycle memory: one commit per clock.
    for (int i = 0; i < 5; i++) runCycle("seq.commit", 5'b11010);
    checkRegs("seq", 16'h0000, 16'd5);

    // 3-cycle memory latency, three fetches.
    for (int i = 0; i < 3; i++) begin
      setIn(1'b0, 1'b0, 16'h0000, 1'b0);
      runCycle("lat.wait1", 5'b10000);
      runCycle("lat.wait2", 5'b10000);
      setIn(1'b0, 1'b0, 16'h0000, 1'b1);
      runCycle("lat.commit", 5'b11010);
    end
    checkRegs("lat", 16'h0000, 16'd8);

    // Stall with data ready: discard, drop request while stalled.
    setIn(1'b1, 1'b0, 16'h0000, 1'b1);
    runCycle("stall.enter", 5'b10000);
    setIn(1'b1, 1'b0, 16'h0000, 1'b0);
    runCycle("stall.hold1", 5'b00000);
    runCycle("stall.hold2", 5'b00000);
    setIn(1'b0, 1'b0, 16'h0000, 1'b0);
    runCycle("stall.release", 5'b00000);
    setIn(1'b0, 1'b0, 16'h0000, 1'b1);
    runCycle("stall.refetch", 5'b11010);
    checkRegs("stall", 16'h0000, 16'd9);

    // Stall without data ready keeps the request open in FETCH.
    setIn(1'b1, 1'b0, 16'h0000, 1'b0);
    runCycle("stallnr.open", 5'b10000);
    setIn(1'b0, 1'b0, 16'h0000, 1'b1);
    runCycle("stallnr.commit", 5'b11010);

    // Branch during a pending request -> DRAIN, redirect on memReady.
    setIn(1'b0, 1'b0, 16'h0000, 1'b0);
    runCycle("drain.pend", 5'b10000);
    setIn(1'b0, 1'b1, 16'h0040, 1'b0);
    runCycle("drain.branch", 5'b10001);
    checkRegs("drain.latched", 16'h0040, 16'd10);
    setIn(1'b1, 1'b0, 16'h0000, 1'b0);
    runCycle("drain.hold", 5'b10001);
    setIn(1'b0, 1'b0, 16'h0000, 1'b1);
    runCycle("drain.redirect", 5'b11101);
    checkRegs("drain.done", 16'h0040, 16'd10);
    runCycle("drain.next", 5'b11010);

    // Two branches while draining: newest target wins.
    setIn(1'b0, 1'b1, 16'h0040, 1'b0);
    runCycle("dbl.first", 5'b10001);
    setIn(1'b0, 1'b1, 16'h0080, 1'b0);
    runCycle("dbl.second", 5'b10001);
    checkRegs("dbl.latched", 16'h0080, 16'd11);
    setIn(1'b0, 1'b0, 16'h0000, 1'b1);
    runCycle("dbl.redirect", 5'b11101);
    checkRegs("dbl.done", 16'h0080, 16'd11);

    // Branch while stalled overrides the stall.
    setIn(1'b1, 1'b0, 16'h0000, 1'b1);
    runCycle("stbr.enter", 5'b10000);
    setIn(1'b1, 1'b1, 16'h1234, 1'b0);
    runCycle("stbr.redirect", 5'b01101);
    checkRegs("stbr", 16'h1234, 16'd11);
    setIn(1'b0, 1'b0, 16'h0000, 1'b1);
    runCycle("stbr.fetch", 5'b11010);

    // Branch with memory ready in FETCH: immediate redirect, no commit.
    setIn(1'b0, 1'b1, 16'h00C0, 1'b1);
    runCycle("brrdy.redirect", 5'b11101);
    checkRegs("brrdy", 16'h00C0, 16'd12);

    // Counter wrap: advance to 0xFFFF with commits, then one more.
    setIn(1'b0, 1'b0, 16'h0000, 1'b1);
    repeat (65535 - 12) @(posedge clock);
    #1;
    checkRegs("wrap.max", 16'h00C0, 16'hFFFF);
    runCycle("wrap.commit", 5'b11010);
    checkRegs("wrap.zero", 16'h00C0, 16'h0000);
    runCycle("wrap.one", 5'b11010);

    // Reset in the middle of DRAIN abandons the redirect.
    setIn(1'b0, 1'b1, 16'h0055, 1'b0);
    runCycle("rstdrain.branch", 5'b10001);
    checkRegs("rstdrain.pre", 16'h0055, 16'd1);
    reset = 1'b1;
    setIn(1'b0, 1'b1, 16'h0099, 1'b1);
    runCycle("rstdrain.reset", 5'b00000);
    checkRegs("rstdrain.post", 16'h0000, 16'd0);
    reset = 1'b0;
    setIn(1'b0, 1'b0, 16'h0000, 1'b0);
    runCycle("rstdrain.fetch", 5'b10000);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
# fetch_controller

Sequencing controller for the instruction-fetch stage of the 16-bit processor. Drives the PC register write enable, the IF mux select (sequential PC+4 vs. branch target), the instruction-memory request and the IF/ID pipeline-register write/flush. Arbitrates between three event sources: the instruction-memory handshake, the hazard unit's stall and a resolved taken branch from a later stage. Also holds the redirect target and a committed-fetch counter.

## Interface
- ADDR_WIDTH, 16, width of PC / branch target
- COUNT_WIDTH, 16, width of committed-fetch counter

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: hold PC and IF/ID this cycle
- branchTaken  in  1  later stage resolved a taken branch (1-cycle pulse)
- branchTarget  in  ADDR_WIDTH  target address, valid with branchTaken
- memReady  in  1  instruction memory: data valid for current request; only meaningful while memReq=1
- memReq  out  1  fetch request to instruction memory
- PCWrite  out  1  PC register load enable
- PCSrc  out  1  IF mux select: 0 = PC+4, 1 = redirectPC
- IFIDWrite  out  1  IF/ID register load enable
- IFFlush  out  1  clear IF/ID to NOP
- redirectPC  out  ADDR_WIDTH  registered branch target, feeds IF mux input 1
- fetchCount  out  COUNT_WIDTH  number of committed fetches

## Operation
- States: FETCH (memReq=1), STALL (memReq=0, waiting for stall release), DRAIN (memReq=1, pending request completing after a branch; its data is discarded).
- Outputs memReq/PCWrite/PCSrc/IFIDWrite/IFFlush are combinational from state and inputs; redirectPC, fetchCount and state are registered.
- Redirect action (one cycle): PCWrite=1, PCSrc=1, IFFlush=1, IFIDWrite=0; the PC loads the target. In the cycle branchTaken is seen, the mux input is branchTarget passed through (redirectPC <= branchTarget in the same cycle, and PCSrc selects the bypassed value). In DRAIN, the stored redirectPC is used.
- Priority per cycle: reset > branchTaken > memReady/stall.
- FETCH:
  - branchTaken & memReady: redirect now -> FETCH.
  - branchTaken & !memReady: latch target -> DRAIN; PCWrite=0, IFIDWrite=0, IFFlush=1.
  - memReady & !stall: commit: PCWrite=1, PCSrc=0, IFIDWrite=1, fetchCount+1 -> FETCH.
  - memReady & stall: discard data; PCWrite=0, IFIDWrite=0 -> STALL.
  - !memReady & stall: keep request open; PCWrite=0, IFIDWrite=0 -> FETCH.
  - !memReady & !stall: wait -> FETCH.
- STALL: memReq=0, all enables 0. branchTaken: redirect now -> FETCH (branch overrides stall). !stall -> FETCH; the same PC is refetched because PC was never written. Otherwise stay.
- DRAIN: memReq=1, IFFlush=1, enables 0. A new branchTaken overwrites redirectPC (newest wins). memReady: redirect using redirectPC -> FETCH. Stall is ignored in DRAIN.
- fetchCount increments only on commit cycles; it wraps 2^COUNT_WIDTH-1 -> 0.

## Timing
- Reset cycle (reset=1): all combinational outputs 0; next state FETCH, redirectPC <= 0, fetchCount <= 0. Reset mid-DRAIN or mid-STALL abandons the operation. Instruction memory shares reset; memReady during reset is ignored.
- First cycle after reset: memReq=1.
- Single-cycle memory (memReady=1 whenever memReq=1): one commit per clock, 0-cycle bubble.
- N-cycle memory: commit in the cycle memReady rises; PC advances at that edge.
- Branch with memory idle or ready: PC = target at the next edge (1-cycle penalty: the flushed slot). Branch with a request in flight: PC = target at the edge after memReady.
- Stall release: memReq is reasserted in the first cycle after stall falls.

## Test plan
- Reset then single-cycle memory, no stall, 5 cycles -> PCWrite=1, PCSrc=0, IFIDWrite=1 every cycle; fetchCount=5; outputs all 0 during reset.
- 3-cycle memory latency -> memReq held high; PCWrite/IFIDWrite pulse once per 3 cycles; after 9 cycles fetchCount=3.
- Stall=1 arriving with memReady for 2 cycles -> FETCH->STALL, memReq=0 for 2 cycles, no commit; memReq=1 in the cycle after release and the same PC is refetched.
- branchTaken, target 0x0040, during a pending 3-cycle request -> DRAIN, IFFlush held, redirectPC=0x0040; on memReady PCWrite=1, PCSrc=1; data discarded; fetchCount unchanged.
- Two branches in DRAIN (0x0040, then 0x0080) -> the redirect uses 0x0080. Branch while in STALL -> immediate redirect, stall overridden.
- fetchCount preset near 0xFFFF via 65535 commits (or forced), then 1 more commit -> wraps to 0x0000. Reset asserted mid-DRAIN -> state FETCH, redirectPC=0, fetchCount=0.
